// File: rtl/mbox_req_arb_if.sv
// Request/response bundle between the three EBOX-side requesters, the MBOX and the arbiter.
// Addresses are PDP-10 bits [13:35], carried here as [22:0] with bit 22 = PDP bit 13.
interface mbox_req_arb_if;
    logic        piReq;
    logic        piWrite;
    logic [22:0] piAdr;
    logic        piAck;
    logic        piErr;

    logic        eboxReq;
    logic        eboxWrite;
    logic [22:0] eboxAdr;
    logic        eboxAck;
    logic        eboxErr;

    logic        cclReq;
    logic        cclWrite;
    logic [22:0] cclAdr;
    logic        cclAck;
    logic        cclErr;

    logic        MBOX_REQ;
    logic        MBOX_WRITE;
    logic [22:0] MBOX_ADR;
    logic [1:0]  MBOX_SRC;
    logic        mboxRespIn;
    logic        mboxRetry;

    logic        clrErr;
    logic        busy;
    logic        errFlag;

    modport master (
        output piReq, piWrite, piAdr,
        output eboxReq, eboxWrite, eboxAdr,
        output cclReq, cclWrite, cclAdr,
        output mboxRespIn, mboxRetry, clrErr,
        input  piAck, piErr, eboxAck, eboxErr, cclAck, cclErr,
        input  MBOX_REQ, MBOX_WRITE, MBOX_ADR, MBOX_SRC,
        input  busy, errFlag
    );

    modport slave (
        input  piReq, piWrite, piAdr,
        input  eboxReq, eboxWrite, eboxAdr,
        input  cclReq, cclWrite, cclAdr,
        input  mboxRespIn, mboxRetry, clrErr,
        output piAck, piErr, eboxAck, eboxErr, cclAck, cclErr,
        output MBOX_REQ, MBOX_WRITE, MBOX_ADR, MBOX_SRC,
        output busy, errFlag
    );
endinterface

// File: rtl/mbox_req_arb.sv
// MBOX reference arbiter: PI fixed priority, EBOX/CCL round-robin; one reference in
// flight, reissued on cache retry, turned into an error on retry overrun or timeout.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | no owner; sample requests, grant one
//  S_ISSUE | MBOX_REQ strobe for the owner's latched reference
//  S_WAIT  | waiting for response / retry, waitCnt running
//  S_DONE  | owner's Ack pulse
//  S_ERR   | owner's Err pulse, errFlag set
module mbox_req_arb #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            CROBAR,
    mbox_req_arb_if.slave   arb_if
);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_PI   = 2'd1;
    localparam logic [1:0] SRC_EBOX = 2'd2;
    localparam logic [1:0] SRC_CCL  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic          write_q, write_d;
    logic [22:0]   adr_q, adr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rr_ccl_q, rr_ccl_d;
    logic          err_flag_q, err_flag_d;

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_NONE;
            write_q    <= 1'b0;
            adr_q      <= '0;
            retry_q    <= '0;
            wait_q     <= '0;
            rr_ccl_q   <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            write_q    <= write_d;
            adr_q      <= adr_d;
            retry_q    <= retry_d;
            wait_q     <= wait_d;
            rr_ccl_q   <= rr_ccl_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        write_d  = write_q;
        adr_d    = adr_q;
        retry_d  = retry_q;
        wait_d   = wait_q;
        rr_ccl_d = rr_ccl_q;

        case (state_q)
            S_IDLE: begin
                if (arb_if.piReq) begin
                    src_d   = SRC_PI;
                    write_d = arb_if.piWrite;
                    adr_d   = arb_if.piAdr;
                    retry_d = '0;
                    state_d = S_ISSUE;
                end else if (arb_if.eboxReq && (!arb_if.cclReq || !rr_ccl_q)) begin
                    // a lone requester is granted even when it is not its turn
                    src_d    = SRC_EBOX;
                    write_d  = arb_if.eboxWrite;
                    adr_d    = arb_if.eboxAdr;
                    retry_d  = '0;
                    rr_ccl_d = 1'b1;
                    state_d  = S_ISSUE;
                end else if (arb_if.cclReq) begin
                    src_d    = SRC_CCL;
                    write_d  = arb_if.cclWrite;
                    adr_d    = arb_if.cclAdr;
                    retry_d  = '0;
                    rr_ccl_d = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (arb_if.mboxRespIn) begin
                    state_d = S_DONE;
                end else if (arb_if.mboxRetry) begin
                    if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                src_d   = SRC_NONE;
                state_d = S_IDLE;
            end
            default: begin
                src_d   = SRC_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // entering ERR outranks a simultaneous clear
    always_comb begin
        err_flag_d = err_flag_q;
        if (state_d == S_ERR) begin
            err_flag_d = 1'b1;
        end else if (arb_if.clrErr) begin
            err_flag_d = 1'b0;
        end
    end

    assign arb_if.MBOX_REQ   = (state_q == S_ISSUE);
    assign arb_if.MBOX_WRITE = write_q;
    assign arb_if.MBOX_ADR   = adr_q;
    assign arb_if.MBOX_SRC   = src_q;

    assign arb_if.piAck   = (state_q == S_DONE) && (src_q == SRC_PI);
    assign arb_if.eboxAck = (state_q == S_DONE) && (src_q == SRC_EBOX);
    assign arb_if.cclAck  = (state_q == S_DONE) && (src_q == SRC_CCL);
    assign arb_if.piErr   = (state_q == S_ERR)  && (src_q == SRC_PI);
    assign arb_if.eboxErr = (state_q == S_ERR)  && (src_q == SRC_EBOX);
    assign arb_if.cclErr  = (state_q == S_ERR)  && (src_q == SRC_CCL);

    assign arb_if.busy    = (state_q != S_IDLE);
    assign arb_if.errFlag = err_flag_q;
endmodule

// File: tb/tb_mbox_req_arb.sv
// Bench for mbox_req_arb: directed scenarios then randomized references, checked
// against a transaction-level model of grant order, retry budget and timeout.
module tb_mbox_req_arb;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 3;

    localparam int K_IDLE  = 0;
    localparam int K_ISSUE = 1;
    localparam int K_WAIT  = 2;
    localparam int K_DONE  = 3;
    localparam int K_ERR   = 4;

    localparam int EV_RESP       = 0;
    localparam int EV_RESP_RETRY = 1;
    localparam int EV_TIMEOUT    = 2;

    logic clk;
    logic CROBAR;
    mbox_req_arb_if bus ();

    mbox_req_arb #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk    (clk),
        .CROBAR (CROBAR),
        .arb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester model: index 0 PI, 1 EBOX, 2 CCL
    bit          hold [3];
    logic [22:0] radr [3];
    logic        rwr  [3];
    bit          rr_ebox;
    bit          exp_err_flag;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.piReq     = hold[0];
        bus.piWrite   = rwr[0];
        bus.piAdr     = radr[0];
        bus.eboxReq   = hold[1];
        bus.eboxWrite = rwr[1];
        bus.eboxAdr   = radr[1];
        bus.cclReq    = hold[2];
        bus.cclWrite  = rwr[2];
        bus.cclAdr    = radr[2];
    endtask

    task automatic exp_cycle(input string tag, input int kind, input int w);
        logic [2:0] one;
        one = 3'b100 >> w;
        chk(tag, "req", 32'(bus.MBOX_REQ), 32'(kind == K_ISSUE));
        chk(tag, "ack", 32'({bus.piAck, bus.eboxAck, bus.cclAck}), 32'((kind == K_DONE) ? one : 3'b000));
        chk(tag, "err", 32'({bus.piErr, bus.eboxErr, bus.cclErr}), 32'((kind == K_ERR) ? one : 3'b000));
        chk(tag, "busy", 32'(bus.busy), 32'(kind != K_IDLE));
        chk(tag, "src", 32'(bus.MBOX_SRC), (kind == K_IDLE) ? 32'd0 : 32'(w + 1));
        if (kind != K_IDLE) begin
            chk(tag, "adr", 32'(bus.MBOX_ADR), 32'(radr[w]));
            chk(tag, "write", 32'(bus.MBOX_WRITE), 32'(rwr[w]));
        end
        if (kind != K_ERR)
            chk(tag, "errFlag", 32'(bus.errFlag), 32'(exp_err_flag));
    endtask

    // One reference: raise the requested lines, predict the winner, play nretry
    // retries followed by the final event, and check every cycle on the way.
    task automatic do_txn(input bit np, input bit ne, input bit nc, input int nretry,
                          input int fin, input int dfin, input bit do_rst);
        bit nreq [3];
        int w;
        int retries;
        int d;
        bit done;
        bit is_retry;
        nreq[0] = np; nreq[1] = ne; nreq[2] = nc;
        for (int i = 0; i < 3; i++) begin
            if (nreq[i] && !hold[i]) begin
                hold[i] = 1'b1;
                radr[i] = 23'($urandom);
                rwr[i]  = ($urandom_range(0, 1) == 1);
            end
        end
        drive_reqs();
        if (hold[0])                 w = 0;
        else if (hold[1] && hold[2]) w = rr_ebox ? 1 : 2;
        else if (hold[1])            w = 1;
        else                         w = 2;
        if (w != 0) rr_ebox = (w == 2);

        bus.clrErr     = ($urandom_range(0, 3) == 0);
        bus.mboxRespIn = ($urandom_range(0, 3) == 0);
        bus.mboxRetry  = ($urandom_range(0, 3) == 0);
        if (bus.clrErr) exp_err_flag = 1'b0;
        tick();
        bus.clrErr = 1'b0; bus.mboxRespIn = 1'b0; bus.mboxRetry = 1'b0;
        exp_cycle("issue", K_ISSUE, w);
        bus.mboxRetry = ($urandom_range(0, 4) == 0);

        if (do_rst) begin
            tick(); bus.mboxRetry = 1'b0;
            exp_cycle("rst_wait", K_WAIT, w);
            tick();
            exp_cycle("rst_wait", K_WAIT, w);
            CROBAR = 1'b1;
            rr_ebox = 1'b1;
            exp_err_flag = 1'b0;
            #1;
            exp_cycle("rst_async", K_IDLE, w);
            tick();
            exp_cycle("rst_held", K_IDLE, w);
            CROBAR = 1'b0;
            return;
        end

        retries = 0;
        done = 1'b0;
        while (!done) begin
            is_retry = (retries < nretry);
            if (!is_retry && fin == EV_TIMEOUT) begin
                repeat (TIMEOUT) begin
                    tick(); bus.mboxRetry = 1'b0;
                    exp_cycle("wait_to", K_WAIT, w);
                end
                tick();
                exp_cycle("timeout_err", K_ERR, w);
                exp_err_flag = 1'b1;
                done = 1'b1;
            end else begin
                d = (is_retry || dfin < 0) ? int'($urandom_range(0, 6)) : dfin;
                repeat (d + 1) begin
                    tick(); bus.mboxRetry = 1'b0;
                    exp_cycle("wait", K_WAIT, w);
                end
                if (is_retry) begin
                    bus.mboxRetry = 1'b1;
                end else begin
                    bus.mboxRespIn = 1'b1;
                    bus.mboxRetry  = (fin == EV_RESP_RETRY);
                end
                tick();
                bus.mboxRetry = 1'b0; bus.mboxRespIn = 1'b0;
                if (is_retry) begin
                    retries++;
                    if (retries <= MAX_RETRY) begin
                        exp_cycle("reissue", K_ISSUE, w);
                    end else begin
                        exp_cycle("retry_err", K_ERR, w);
                        exp_err_flag = 1'b1;
                        done = 1'b1;
                    end
                end else begin
                    exp_cycle("ack", K_DONE, w);
                    done = 1'b1;
                end
            end
        end
        hold[w] = 1'b0;
        drive_reqs();
        tick();
        exp_cycle("idle", K_IDLE, w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            hold[i] = 1'b0; radr[i] = '0; rwr[i] = 1'b0;
        end
        rr_ebox = 1'b1;
        exp_err_flag = 1'b0;
        CROBAR = 1'b1;
        bus.mboxRespIn = 1'b0;
        bus.mboxRetry  = 1'b0;
        bus.clrErr     = 1'b0;
        drive_reqs();
        tick(); tick();
        exp_cycle("reset", K_IDLE, 0);
        chk("reset", "adr", 32'(bus.MBOX_ADR), 32'd0);
        chk("reset", "write", 32'(bus.MBOX_WRITE), 32'd0);
        CROBAR = 1'b0;
        tick();
        exp_cycle("post_reset", K_IDLE, 0);

        // single EBOX read, response in the third cycle after the strobe
        hold[1] = 1'b1; radr[1] = 23'h012345; rwr[1] = 1'b0;
        do_txn(0, 0, 0, 0, EV_RESP, 1, 0);

        // all three at once, then EBOX/CCL kept requesting
        do_txn(1, 1, 1, 0, EV_RESP, -1, 0);
        for (int n = 0; n < 5; n++) do_txn(0, 1, 1, 0, EV_RESP, -1, 0);
        for (int i = 0; i < 2; i++) begin
            if (hold[i + 1]) do_txn(0, 0, 0, 0, EV_RESP, -1, 0);
        end

        // full retry budget then success
        do_txn(0, 0, 1, MAX_RETRY, EV_RESP, -1, 0);
        // retry overrun, then clear the sticky flag
        do_txn(0, 1, 0, MAX_RETRY + 1, EV_RESP, -1, 0);
        bus.clrErr = 1'b1;
        tick();
        bus.clrErr = 1'b0;
        exp_err_flag = 1'b0;
        exp_cycle("clr_err", K_IDLE, 0);

        // silent MBOX, then response racing a retry, then response on the last legal cycle
        do_txn(1, 0, 0, 0, EV_TIMEOUT, -1, 0);
        do_txn(0, 1, 0, 0, EV_RESP_RETRY, -1, 0);
        do_txn(0, 0, 1, 1, EV_RESP, TIMEOUT - 1, 0);

        // reset mid-reference; both EBOX and CCL then held, pointer back on EBOX
        do_txn(0, 1, 0, 0, EV_RESP, -1, 1);
        do_txn(0, 0, 1, 0, EV_RESP, -1, 0);

        for (int n = 0; n < 40; n++) begin
            bit p, e, c;
            int nr, f;
            p  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 1) == 1);
            if (!p && !e && !c && !hold[0] && !hold[1] && !hold[2]) e = 1'b1;
            nr = int'($urandom_range(0, 4));
            f  = int'($urandom_range(0, 7));
            f  = (f == 7) ? EV_TIMEOUT : (f >= 5) ? EV_RESP_RETRY : EV_RESP;
            do_txn(p, e, c, nr, f, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
